// File: rtl/cv32e40p_if_id_queue.sv
// ---------------------------------------------------------------------------
// cv32e40p_if_id_queue
//
// IF/ID decoupling queue. Stores up to DEPTH decompressed fetch results
// (instruction, PC, compressed / illegal-compressed / fetch-failed flags), so
// the fetch front end keeps running while ID stalls. A flush (clear_i)
// empties the queue on a PC redirect. With FALL_THROUGH=1 an empty queue
// forwards the incoming entry straight to the ID outputs in the same cycle.
//
// Handshake (both sides use strict valid/ready): a transfer happens in a
// cycle where valid and ready are both 1. Valid never depends on ready on the
// same side. if_ready_o is register-derived (~full_o), so there is no
// combinational id_ready_i -> if_ready_o path. A push also requires
// halt_if_i = 0 and clear_i = 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   if_*_i / if_ready_o   producer side (aligner / compressed decoder)
//   halt_if_i, clear_i    push blocking, flush
//   id_ready_i, *_id_o    consumer side (ID stage), head entry
//   occupancy_o, full_o   stored entry count, full flag (registered)
//   perf_imiss_o          ID ready but starved this cycle
// ---------------------------------------------------------------------------
module cv32e40p_if_id_queue #(
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b0,
  parameter int INSTR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [INSTR_WIDTH-1:0]     if_instr_i,
  input  logic [31:0]                if_pc_i,
  input  logic                       if_is_compressed_i,
  input  logic                       if_illegal_c_i,
  input  logic                       if_fetch_failed_i,
  input  logic                       halt_if_i,
  input  logic                       clear_i,
  input  logic                       id_ready_i,
  output logic                       instr_valid_id_o,
  output logic [INSTR_WIDTH-1:0]     instr_rdata_id_o,
  output logic [31:0]                pc_id_o,
  output logic                       is_compressed_id_o,
  output logic                       illegal_c_insn_id_o,
  output logic                       is_fetch_failed_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       full_o,
  output logic                       perf_imiss_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [31:0]            pc_mem    [DEPTH];
  logic [2:0]             flag_mem  [DEPTH];  // {compressed, illegal_c, fetch_failed}

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  logic empty;
  logic full;
  logic push;
  logic pop_store;
  logic ft_active;
  logic bypass;
  logic wr_en;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  assign push      = if_valid_i & ~full & ~halt_if_i & ~clear_i;
  // Only a stored head is popped from storage; a forwarded entry is not.
  assign pop_store = ~empty & id_ready_i;

  // Fall-through: an empty queue shows the incoming entry directly.
  assign ft_active = FALL_THROUGH & empty & if_valid_i & ~halt_if_i & ~clear_i;
  // Forwarded and consumed in the same cycle: never stored.
  assign bypass    = ft_active & id_ready_i;
  assign wr_en     = push & ~bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
        flag_mem[i]  <= '0;
      end
    end else if (clear_i) begin
      // Flush: input on this cycle is dropped, queue restarts at slot 0.
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        instr_mem[wr_ptr_q] <= if_instr_i;
        pc_mem[wr_ptr_q]    <= if_pc_i;
        flag_mem[wr_ptr_q]  <= {if_is_compressed_i, if_illegal_c_i, if_fetch_failed_i};
        wr_ptr_q            <= next_ptr(wr_ptr_q);
      end
      if (pop_store) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({wr_en, pop_store})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    instr_valid_id_o    = ~empty;
    instr_rdata_id_o    = instr_mem[rd_ptr_q];
    pc_id_o             = pc_mem[rd_ptr_q];
    is_compressed_id_o  = flag_mem[rd_ptr_q][2];
    illegal_c_insn_id_o = flag_mem[rd_ptr_q][1];
    is_fetch_failed_o   = flag_mem[rd_ptr_q][0];
    if (ft_active) begin
      instr_valid_id_o    = 1'b1;
      instr_rdata_id_o    = if_instr_i;
      pc_id_o             = if_pc_i;
      is_compressed_id_o  = if_is_compressed_i;
      illegal_c_insn_id_o = if_illegal_c_i;
      is_fetch_failed_o   = if_fetch_failed_i;
    end
  end

  assign occupancy_o  = count_q;
  assign full_o       = full;
  assign if_ready_o   = ~full;
  assign perf_imiss_o = id_ready_i & ~instr_valid_id_o & ~clear_i;

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// ---------------------------------------------------------------------------
// Bench for cv32e40p_if_id_queue. Two instances share clk/rst:
//   a: DEPTH=3, FALL_THROUGH=0
//   b: DEPTH=2, FALL_THROUGH=1
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge against a queue-based reference model of each instance.
// ---------------------------------------------------------------------------
module tb_cv32e40p_if_id_queue;

  localparam int W = 67;  // {pc, instr, compressed, illegal_c, fetch_failed}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- instance a signals ----------------
  logic        a_valid, a_if_ready, a_c, a_ill, a_ff, a_halt, a_clear, a_ready;
  logic [31:0] a_instr, a_pc;
  logic        a_v_id, a_c_id, a_ill_id, a_ff_id, a_full, a_imiss;
  logic [31:0] a_instr_id, a_pc_id;
  logic [1:0]  a_occ;

  // ---------------- instance b signals ----------------
  logic        b_valid, b_if_ready, b_c, b_ill, b_ff, b_halt, b_clear, b_ready;
  logic [31:0] b_instr, b_pc;
  logic        b_v_id, b_c_id, b_ill_id, b_ff_id, b_full, b_imiss;
  logic [31:0] b_instr_id, b_pc_id;
  logic [1:0]  b_occ;

  cv32e40p_if_id_queue #(.DEPTH(3), .FALL_THROUGH(1'b0), .INSTR_WIDTH(32)) u_a (
    .clk(clk), .rst(rst),
    .if_valid_i(a_valid), .if_ready_o(a_if_ready), .if_instr_i(a_instr), .if_pc_i(a_pc),
    .if_is_compressed_i(a_c), .if_illegal_c_i(a_ill), .if_fetch_failed_i(a_ff),
    .halt_if_i(a_halt), .clear_i(a_clear), .id_ready_i(a_ready),
    .instr_valid_id_o(a_v_id), .instr_rdata_id_o(a_instr_id), .pc_id_o(a_pc_id),
    .is_compressed_id_o(a_c_id), .illegal_c_insn_id_o(a_ill_id), .is_fetch_failed_o(a_ff_id),
    .occupancy_o(a_occ), .full_o(a_full), .perf_imiss_o(a_imiss)
  );

  cv32e40p_if_id_queue #(.DEPTH(2), .FALL_THROUGH(1'b1), .INSTR_WIDTH(32)) u_b (
    .clk(clk), .rst(rst),
    .if_valid_i(b_valid), .if_ready_o(b_if_ready), .if_instr_i(b_instr), .if_pc_i(b_pc),
    .if_is_compressed_i(b_c), .if_illegal_c_i(b_ill), .if_fetch_failed_i(b_ff),
    .halt_if_i(b_halt), .clear_i(b_clear), .id_ready_i(b_ready),
    .instr_valid_id_o(b_v_id), .instr_rdata_id_o(b_instr_id), .pc_id_o(b_pc_id),
    .is_compressed_id_o(b_c_id), .illegal_c_insn_id_o(b_ill_id), .is_fetch_failed_o(b_ff_id),
    .occupancy_o(b_occ), .full_o(b_full), .perf_imiss_o(b_imiss)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] a_exp_q[$];
  logic [W-1:0] b_exp_q[$];
  int a_cnt;
  int b_cnt;
  int n_checks;
  int n_pass;
  int n_fail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [31:0] pc, input logic [31:0] ins,
                                      input logic c, input logic il, input logic ff);
    return {pc, ins, c, il, ff};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic a_drive(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic hlt, input logic clr);
    a_valid = v;       a_pc  = pc;    a_instr = {pc[15:0], ~pc[15:0]};
    a_c     = pc[2];   a_ill = pc[3]; a_ff    = pc[4];
    a_ready = rdy;     a_halt = hlt;  a_clear = clr;
  endtask

  task automatic b_drive(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic hlt, input logic clr);
    b_valid = v;       b_pc  = pc;    b_instr = {~pc[15:0], pc[15:0]};
    b_c     = pc[2];   b_ill = pc[3]; b_ff    = pc[4];
    b_ready = rdy;     b_halt = hlt;  b_clear = clr;
  endtask

  // One clock cycle: check both instances at the falling edge, advance the
  // models to what the next rising edge does, then move to edge + 1.
  task automatic tick();
    logic         a_push, a_pop;
    logic         b_ft, b_vexp, b_push, b_pop;
    logic [W-1:0] b_head;
    @(negedge clk);
    // instance a (no fall-through)
    a_push = a_valid && (a_cnt < 3) && !a_halt && !a_clear;
    a_pop  = a_ready && (a_cnt != 0);
    chk("a_valid",    a_v_id,     a_cnt != 0);
    chk("a_occ",      a_occ,      a_cnt);
    chk("a_full",     a_full,     a_cnt == 3);
    chk("a_if_ready", a_if_ready, a_cnt != 3);
    chk("a_imiss",    a_imiss,    a_ready && (a_cnt == 0) && !a_clear);
    if (a_cnt != 0)
      chk("a_head", pk(a_pc_id, a_instr_id, a_c_id, a_ill_id, a_ff_id), a_exp_q[0]);
    if (a_pop) void'(a_exp_q.pop_front());
    if (a_clear) a_exp_q.delete();
    else if (a_push) a_exp_q.push_back(pk(a_pc, a_instr, a_c, a_ill, a_ff));
    a_cnt = a_exp_q.size();
    // instance b (fall-through)
    b_ft   = (b_cnt == 0) && b_valid && !b_halt && !b_clear;
    b_vexp = (b_cnt != 0) || b_ft;
    b_head = (b_cnt != 0) ? b_exp_q[0] : pk(b_pc, b_instr, b_c, b_ill, b_ff);
    b_pop  = b_vexp && b_ready;
    b_push = b_valid && (b_cnt < 2) && !b_halt && !b_clear;
    chk("b_valid",    b_v_id,     b_vexp);
    chk("b_occ",      b_occ,      b_cnt);
    chk("b_full",     b_full,     b_cnt == 2);
    chk("b_if_ready", b_if_ready, b_cnt != 2);
    chk("b_imiss",    b_imiss,    b_ready && !b_vexp && !b_clear);
    if (b_vexp)
      chk("b_head", pk(b_pc_id, b_instr_id, b_c_id, b_ill_id, b_ff_id), b_head);
    if (b_clear) b_exp_q.delete();
    else begin
      if (b_pop && (b_cnt != 0)) void'(b_exp_q.pop_front());
      if (b_push && !(b_ft && b_ready)) b_exp_q.push_back(pk(b_pc, b_instr, b_c, b_ill, b_ff));
    end
    b_cnt = b_exp_q.size();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    a_cnt = 0; b_cnt = 0;
    rst = 1'b1;
    a_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    b_drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    // reset values
    chk("rst_a_valid",    a_v_id,     1'b0);
    chk("rst_a_pc",       a_pc_id,    32'h0);
    chk("rst_a_instr",    a_instr_id, 32'h0);
    chk("rst_a_flags",    {a_c_id, a_ill_id, a_ff_id}, 3'b000);
    chk("rst_a_occ",      a_occ,      2'd0);
    chk("rst_a_full",     a_full,     1'b0);
    chk("rst_a_if_ready", a_if_ready, 1'b1);
    chk("rst_a_imiss",    a_imiss,    1'b1);
    chk("rst_b_valid",    b_v_id,     1'b0);
    chk("rst_b_imiss",    b_imiss,    1'b0);
    rst = 1'b0;

    // fill to full, 4th push ignored, then drain in order
    a_drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h10c, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    end

    // wrap-around: back-to-back pushes with continuous pops
    for (int i = 0; i < 10; i++) begin
      a_drive(1'b1, 32'h600 + 32'(4 * i), 1'b1, 1'b0, 1'b0); tick();
    end
    a_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();

    // flush with a concurrent push that must be dropped
    a_drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1); tick();
    a_drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b0, 32'h0,   1'b1, 1'b0, 1'b0); tick();
    tick();

    // halt on empty queue: starvation cycles, no push; clear wins over halt
    for (int i = 0; i < 3; i++) begin
      a_drive(1'b1, 32'h700, 1'b1, 1'b1, 1'b0); tick();
    end
    a_drive(1'b1, 32'h704, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h708, 1'b0, 1'b1, 1'b1); tick();
    a_drive(1'b0, 32'h0,   1'b1, 1'b0, 1'b0); tick();

    // random traffic on a
    for (int i = 0; i < 80; i++) begin
      a_drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      tick();
    end

    // reset mid-stream with two entries held: outputs drop without a clock edge
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    end
    a_drive(1'b1, 32'h800, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b1, 32'h804, 1'b0, 1'b0, 1'b0); tick();
    a_drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_a_occ", a_occ, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_a_valid",    a_v_id,     1'b0);
    chk("mid_rst_a_occ",      a_occ,      2'd0);
    chk("mid_rst_a_if_ready", a_if_ready, 1'b1);
    chk("mid_rst_a_pc",       a_pc_id,    32'h0);
    a_exp_q.delete(); a_cnt = 0;
    b_exp_q.delete(); b_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fall-through: forwarded and consumed, then forwarded and stored
    b_drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0); tick();
    b_drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0); tick();
    b_drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0); tick();
    b_drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0); tick();
    b_drive(1'b1, 32'h408, 1'b1, 1'b0, 1'b0); tick();
    b_drive(1'b1, 32'h40c, 1'b0, 1'b0, 1'b0); tick();
    b_drive(1'b1, 32'h410, 1'b0, 1'b0, 1'b0); tick();
    b_drive(1'b0, 32'h0,   1'b1, 1'b0, 1'b0); tick();
    tick();
    tick();

    // random traffic on b
    for (int i = 0; i < 80; i++) begin
      b_drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
